sm3_msg_pad_stream: RTL and testbench

//  Parametrised SM3 message padder with valid/ready handshakes on both sides. Accepts a
//  big-endian byte stream in WORD_W-bit words, appends 0x80, zero fill and the 64-bit bit

---
 rtl/sm3_pkg.sv | 17 +
 rtl/sm3_pad_word_mask.sv | 35 +++
 rtl/sm3_msg_pad_stream.sv | 229 ++++++++++++++++++++++
 tb/tb_sm3_msg_pad_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// Shared SM3 padding constants and pad-engine state encoding.
package sm3_pkg;

    localparam int unsigned SM3_BLK_W       = 512;
    localparam int unsigned SM3_LEN_FIELD_W = 64;
    localparam int unsigned SM3_LEN_POS     = SM3_BLK_W - SM3_LEN_FIELD_W;
    localparam logic [7:0]  SM3_PAD_BYTE    = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StEmit,
        StLenOnly,
        StPadOnly
    } pad_state_e;

endpackage

// File: rtl/sm3_pad_word_mask.sv
// Masks the unused bytes of a message's final word and inserts the 0x80 pad byte.
// spill_out flags a full word, where the pad byte lands in the following word.
module sm3_pad_word_mask
    import sm3_pkg::*;
#(
    parameter int unsigned  WORD_W = 32,
    localparam int unsigned NB_W   = $clog2(WORD_W / 8) + 1
) (
    input  logic [WORD_W-1:0] word_in,
    input  logic [NB_W-1:0]   nbytes_in,
    output logic [WORD_W-1:0] word_out,
    output logic              spill_out
);
    localparam int unsigned BYTES = WORD_W / 8;

    logic [NB_W-1:0] nb_eff;

    always_comb begin
        nb_eff = nbytes_in;
        if (nbytes_in == '0 || nbytes_in > NB_W'(BYTES)) begin
            nb_eff = NB_W'(BYTES);
        end
        word_out = '0;
        // Byte 0 is the most significant byte of the word.
        for (int b = 0; b < int'(BYTES); b++) begin
            if (b < int'(nb_eff)) begin
                word_out[int'(WORD_W) - 1 - 8 * b -: 8] = word_in[int'(WORD_W) - 1 - 8 * b -: 8];
            end else if (b == int'(nb_eff)) begin
                word_out[int'(WORD_W) - 1 - 8 * b -: 8] = SM3_PAD_BYTE;
            end
        end
        spill_out = (nb_eff == NB_W'(BYTES));
    end

endmodule

// File: rtl/sm3_msg_pad_stream.sv
// SM3 message padder: big-endian word stream in, padded 512-bit blocks out.
// Define SM3_PAD_LEN_OVF_EN to add the sticky length-overflow flag err_ovf_out.
module sm3_msg_pad_stream
    import sm3_pkg::*;
#(
    parameter int unsigned  WORD_W = 32,
    parameter int unsigned  LEN_W  = 64,
    localparam int unsigned NB_W   = $clog2(WORD_W / 8) + 1
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic                 start_in,
    input  logic                 empty_msg_in,
    input  logic                 msg_valid_in,
    output logic                 msg_ready_out,
    input  logic [WORD_W-1:0]    msg_data_in,
    input  logic                 msg_last_in,
    input  logic [NB_W-1:0]      msg_nbytes_in,
    output logic                 blk_valid_out,
    input  logic                 blk_ready_in,
    output logic [SM3_BLK_W-1:0] blk_data_out,
    output logic                 blk_first_out,
    output logic                 blk_last_out,
    output logic                 busy_out
`ifdef SM3_PAD_LEN_OVF_EN
    ,
    output logic                 err_ovf_out
`endif
);
    localparam int unsigned N     = SM3_BLK_W / WORD_W;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned BYTES = WORD_W / 8;

    pad_state_e                 state_q, state_d, after_q, after_d;
    logic                       first_q, first_d, last_q, last_d;
    logic [SM3_BLK_W-1:0]       buf_q, tail_blk, len_blk;
    logic [IDX_W-1:0]           idx_q;
    logic [LEN_W-1:0]           len_q, len_sum, add_bits;
    logic [NB_W-1:0]            nb_eff;
    logic [WORD_W-1:0]          masked_word;
    logic [SM3_LEN_FIELD_W-1:0] len_field_sum, len_field_q;
    logic                       spill, fits, pad_only, word_hs, start_ok;
    int                         end_bit;

    sm3_pad_word_mask #(
        .WORD_W(WORD_W)
    ) u_word_mask (
        .word_in  (msg_data_in),
        .nbytes_in(msg_nbytes_in),
        .word_out (masked_word),
        .spill_out(spill)
    );

    assign msg_ready_out = (state_q == StFill);
    assign blk_valid_out = (state_q == StEmit) || (state_q == StLenOnly) ||
                           (state_q == StPadOnly);
    assign blk_first_out = blk_valid_out & first_q;
    assign blk_last_out  = blk_valid_out & last_q;
    assign blk_data_out  = buf_q;
    assign busy_out      = (state_q != StIdle);
    assign word_hs       = msg_valid_in & msg_ready_out;
    assign start_ok      = (state_q == StIdle) & start_in;

    always_comb begin
        nb_eff = msg_nbytes_in;
        if (!msg_last_in || msg_nbytes_in == '0 || msg_nbytes_in > NB_W'(BYTES)) begin
            nb_eff = NB_W'(BYTES);
        end
        add_bits = '0;
        add_bits[NB_W+2:0] = {nb_eff, 3'b000};
    end

`ifdef SM3_PAD_LEN_OVF_EN
    logic len_carry, err_q;

    assign {len_carry, len_sum} = {1'b0, len_q} + {1'b0, add_bits};
    assign err_ovf_out = err_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (word_hs && len_carry) begin
            err_q <= 1'b1;
        end
    end
`else
    assign len_sum = len_q + add_bits;
`endif

    always_comb begin
        len_field_sum = '0;
        len_field_sum[LEN_W-1:0] = len_sum;
        len_field_q = '0;
        len_field_q[LEN_W-1:0] = len_q;
    end

    // Final block of the message as it would look after the last word lands.
    always_comb begin
        if (spill) begin
            end_bit = (int'(idx_q) + 1) * int'(WORD_W) + 8;
        end else begin
            end_bit = int'(idx_q) * int'(WORD_W) + (int'(nb_eff) + 1) * 8;
        end
        fits     = (end_bit <= int'(SM3_LEN_POS));
        pad_only = spill && (idx_q == IDX_W'(N - 1));
        tail_blk = buf_q;
        for (int j = 0; j < int'(N); j++) begin
            if (j == int'(idx_q)) begin
                tail_blk[int'(SM3_BLK_W) - 1 - j * int'(WORD_W) -: WORD_W] = masked_word;
            end else if (spill && j == int'(idx_q) + 1) begin
                tail_blk[int'(SM3_BLK_W) - 1 - j * int'(WORD_W) -: WORD_W] =
                    {SM3_PAD_BYTE, {(WORD_W - 8){1'b0}}};
            end else if (j > int'(idx_q)) begin
                tail_blk[int'(SM3_BLK_W) - 1 - j * int'(WORD_W) -: WORD_W] = '0;
            end
        end
        if (fits) begin
            tail_blk[SM3_LEN_FIELD_W-1:0] = len_field_sum;
        end
    end

    always_comb begin
        len_blk = '0;
        len_blk[SM3_LEN_FIELD_W-1:0] = len_field_q;
        if (after_q == StPadOnly) begin
            len_blk[SM3_BLK_W-1 -: 8] = SM3_PAD_BYTE;
        end
    end

    always_comb begin
        state_d = state_q;
        after_d = after_q;
        first_d = first_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (start_in) begin
                    first_d = 1'b1;
                    last_d  = empty_msg_in;
                    state_d = empty_msg_in ? StPadOnly : StFill;
                end
            end
            StFill: begin
                if (word_hs) begin
                    if (msg_last_in) begin
                        state_d = StEmit;
                        if (pad_only) begin
                            after_d = StPadOnly;
                            last_d  = 1'b0;
                        end else if (!fits) begin
                            after_d = StLenOnly;
                            last_d  = 1'b0;
                        end else begin
                            after_d = StIdle;
                            last_d  = 1'b1;
                        end
                    end else if (idx_q == IDX_W'(N - 1)) begin
                        state_d = StEmit;
                        after_d = StFill;
                        last_d  = 1'b0;
                    end
                end
            end
            StEmit: begin
                if (blk_ready_in) begin
                    state_d = after_q;
                    first_d = 1'b0;
                    last_d  = (after_q == StLenOnly) || (after_q == StPadOnly);
                end
            end
            StLenOnly, StPadOnly: begin
                if (blk_ready_in) begin
                    state_d = StIdle;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= StIdle;
            after_q <= StIdle;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            after_q <= after_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            buf_q <= '0;
            idx_q <= '0;
            len_q <= '0;
        end else if (start_ok) begin
            idx_q <= '0;
            len_q <= '0;
            buf_q <= '0;
            if (empty_msg_in) begin
                buf_q[SM3_BLK_W-1 -: 8] <= SM3_PAD_BYTE;
            end
        end else if (word_hs) begin
            len_q <= len_sum;
            if (msg_last_in) begin
                buf_q <= tail_blk;
                idx_q <= '0;
            end else begin
                for (int j = 0; j < int'(N); j++) begin
                    if (j == int'(idx_q)) begin
                        buf_q[int'(SM3_BLK_W) - 1 - j * int'(WORD_W) -: WORD_W] <= msg_data_in;
                    end
                end
                idx_q <= (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
            end
        end else if (state_q == StEmit && blk_ready_in &&
                     (after_q == StLenOnly || after_q == StPadOnly)) begin
            buf_q <= len_blk;
        end
    end

endmodule

// File: tb/tb_sm3_msg_pad_stream.sv
// Scoreboard bench for sm3_msg_pad_stream: byte-level padding model, randomized traffic.
`timescale 1ns/1ps
module tb_sm3_msg_pad_stream;
    localparam int unsigned W     = 32;
    localparam int unsigned BYTES = W / 8;
    localparam int unsigned NB_W  = $clog2(W / 8) + 1;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   passes   = 0;
    int   rdy_mode = 0;

    logic            clk_in        = 1'b0;
    logic            reset_n_in    = 1'b0;
    logic            start_in      = 1'b0;
    logic            empty_msg_in  = 1'b0;
    logic            msg_valid_in  = 1'b0;
    logic [W-1:0]    msg_data_in   = '0;
    logic            msg_last_in   = 1'b0;
    logic [NB_W-1:0] msg_nbytes_in = '0;
    logic            blk_ready_in  = 1'b0;
    logic            msg_ready_out, blk_valid_out, blk_first_out, blk_last_out, busy_out;
    logic [511:0]    blk_data_out;
`ifdef SM3_PAD_LEN_OVF_EN
    logic            err_ovf_out;
`endif

    sm3_msg_pad_stream #(
        .WORD_W(W),
        .LEN_W (64)
    ) dut (
        .clk_in       (clk_in),
        .reset_n_in   (reset_n_in),
        .start_in     (start_in),
        .empty_msg_in (empty_msg_in),
        .msg_valid_in (msg_valid_in),
        .msg_ready_out(msg_ready_out),
        .msg_data_in  (msg_data_in),
        .msg_last_in  (msg_last_in),
        .msg_nbytes_in(msg_nbytes_in),
        .blk_valid_out(blk_valid_out),
        .blk_ready_in (blk_ready_in),
        .blk_data_out (blk_data_out),
        .blk_first_out(blk_first_out),
        .blk_last_out (blk_last_out),
        .busy_out     (busy_out)
`ifdef SM3_PAD_LEN_OVF_EN
        ,
        .err_ovf_out  (err_ovf_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    function automatic void chk(input bit ok, input string name, input logic [511:0] act,
                                input logic [511:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Reference: message bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic push_expected(input byte_q_t m);
        byte_q_t     p;
        logic [63:0] bitlen;
        int          nblk;
        exp_t        e;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(m.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.d = '0;
            for (int i = 0; i < 64; i++) e.d[511 - 8*i -: 8] = p[b*64 + i];
            e.f = (b == 0);
            e.l = (b == nblk - 1);
            sb.push_back(e);
        end
    endtask

    function automatic byte_q_t rand_msg(input int len);
        byte_q_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy_out && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) chk(1'b0, "busy_timeout", busy_out, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(blk_valid_out == 1'b0, {tag, "_blk_valid"}, blk_valid_out, 0);
        chk(msg_ready_out == 1'b0, {tag, "_msg_ready"}, msg_ready_out, 0);
        chk(busy_out == 1'b0, {tag, "_busy"}, busy_out, 0);
        chk(blk_first_out == 1'b0, {tag, "_first"}, blk_first_out, 0);
        chk(blk_last_out == 1'b0, {tag, "_last"}, blk_last_out, 0);
        chk(blk_data_out == '0, {tag, "_data"}, blk_data_out, 0);
    endtask

    // abort_at >= 0: reset is asserted right after that word's handshake.
    task automatic send_msg(input byte_q_t m, input bit hold, input int abort_at);
        int           nw, nb, n, len;
        logic [W-1:0] word;
        len = m.size();
        wait_idle();
        if (abort_at < 0) push_expected(m);
        if (hold) rdy_mode = 1;
        start_in     = 1'b1;
        empty_msg_in = (len == 0);
        tick();
        start_in     = 1'b0;
        empty_msg_in = 1'b0;
        if (len == 0) return;
        nw = (len + BYTES - 1) / BYTES;
        for (int w = 0; w < nw; w++) begin
            while ($urandom_range(3) == 0) tick();
            word = $urandom;
            for (int b = 0; b < BYTES; b++) begin
                if (w * BYTES + b < len) word[W - 1 - 8*b -: 8] = m[w * BYTES + b];
            end
            msg_valid_in = 1'b1;
            msg_data_in  = word;
            msg_last_in  = (w == nw - 1);
            nb = len - w * BYTES;
            if (w == nw - 1) begin
                msg_nbytes_in = (nb == BYTES && $urandom_range(1) == 1) ? '0 : NB_W'(nb);
            end else begin
                msg_nbytes_in = NB_W'($urandom);
            end
            // Stray starts mid-message must be ignored.
            start_in     = ($urandom_range(7) == 0);
            empty_msg_in = 1'($urandom_range(1));
            n = 0;
            while (!msg_ready_out && n < 1000) begin
                tick();
                n++;
            end
            if (n >= 1000) begin
                chk(1'b0, "msg_ready_timeout", msg_ready_out, 1);
                msg_valid_in = 1'b0;
                start_in     = 1'b0;
                return;
            end
            tick();
            msg_valid_in = 1'b0;
            msg_last_in  = 1'b0;
            start_in     = 1'b0;
            empty_msg_in = 1'b0;
            if (w == abort_at) begin
                reset_n_in = 1'b0;
                #1;
                check_zero_outputs("mid_reset");
                sb.delete();
                tick();
                reset_n_in = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_mode == 1) blk_ready_in = 1'b0;
            else blk_ready_in = ($urandom_range(3) != 0);
        end
    end

    // Monitor: every presented block must equal the head of the scoreboard, stalled or not.
    initial begin
        forever begin
            @(negedge clk_in);
            if (reset_n_in && blk_valid_out) begin
                chk(msg_ready_out == 1'b0, "msg_ready_during_blk", msg_ready_out, 0);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_block", blk_data_out, 0);
                end else begin
                    mon_e = sb[0];
                    chk(blk_data_out == mon_e.d, "blk_data", blk_data_out, mon_e.d);
                    chk(blk_first_out == mon_e.f, "blk_first", blk_first_out, mon_e.f);
                    chk(blk_last_out == mon_e.l, "blk_last", blk_last_out, mon_e.l);
                    if (blk_ready_in) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending %0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t abc;
        #12;
        check_zero_outputs("reset");
        tick();
        reset_n_in = 1'b1;
        tick();
        tick();

        abc = '{8'h61, 8'h62, 8'h63};
        send_msg(abc, 1'b0, -1);
        send_msg(rand_msg(56), 1'b0, -1);
        send_msg(rand_msg(64), 1'b0, -1);
        send_msg(rand_msg(0), 1'b0, -1);
        send_msg(rand_msg(55), 1'b0, -1);
        send_msg(rand_msg(52), 1'b0, -1);
        send_msg(rand_msg(57), 1'b0, -1);
        send_msg(rand_msg(1), 1'b0, -1);
        send_msg(rand_msg(4), 1'b0, -1);
        send_msg(rand_msg(119), 1'b0, -1);
        send_msg(rand_msg(120), 1'b0, -1);
        send_msg(rand_msg(128), 1'b0, -1);

        // Back-pressure on the first block of a 64-byte message.
        send_msg(rand_msg(64), 1'b1, -1);
        for (int i = 0; i < 5; i++) begin
            chk(blk_valid_out == 1'b1, "hold_valid", blk_valid_out, 1);
            chk(msg_ready_out == 1'b0, "hold_msg_ready", msg_ready_out, 0);
            tick();
        end
        rdy_mode = 0;

        send_msg(rand_msg(100), 1'b0, 7);
        send_msg(rand_msg(10), 1'b0, -1);
        send_msg(rand_msg(70), 1'b0, -1);

        for (int i = 0; i < 20; i++) send_msg(rand_msg($urandom_range(150)), 1'b0, -1);

        wait_idle();
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
